// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream over a valid/ready handshake, assembles
// little-endian 32-bit instruction words and writes them to the instruction
// memory at word-aligned byte addresses 0, 4, 8, ...  The core is held off
// (cpu_hold) while a load is receiving or writing.
//
// CNT_W is expected to be 32 or less; load_words is widened to 32 bits for the
// size check.
module imem_loader #(
   parameter int unsigned MEM_BYTES = 36,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_start,
   input  logic [CNT_W-1:0] load_words,
   input  logic             load_abort,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             cpu_hold,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_written
);

   // Largest word count that still fits in the memory.
   localparam int unsigned MAX_WORDS = MEM_BYTES / 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] n_q,     n_d;      // words requested for this load
   logic [CNT_W-1:0] words_q, words_d;  // words committed so far
   logic [1:0]       lane_q,  lane_d;   // next byte lane to fill
   logic [31:0]      addr_q,  addr_d;   // byte address of the word being built
   logic [31:0]      wdata_q, wdata_d;  // word under assembly

   logic start_bad;
   logic last_word;

   // A request is rejected when empty or when it would run past the memory end.
   assign start_bad = (load_words == '0) || (32'(load_words) > MAX_WORDS);

   // The word currently being written is the final one of the load.
   assign last_word = ((words_q + CNT_W'(1)) == n_q);

   // Next-state and datapath update; every state holds its registers by default.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      n_d     = n_q;
      words_d = words_q;
      lane_d  = lane_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            // load_abort is ignored here, so a coincident start still wins.
            if (load_start) begin
               if (start_bad) begin
                  state_d = S_ERR;
               end else begin
                  n_d     = load_words;
                  words_d = '0;
                  lane_d  = 2'd0;
                  addr_d  = 32'd0;
                  state_d = S_RECV;
               end
            end
         end

         S_RECV: begin
            if (load_abort) begin
               // The partially assembled word is dropped, never written.
               lane_d  = 2'd0;
               state_d = S_ERR;
            end else if (byte_valid) begin
               // byte_ready is 1 throughout RECV, so valid alone is a transfer.
               wdata_d[{lane_q, 3'b000} +: 8] = byte_data;
               lane_d = lane_q + 2'd1;
               if (lane_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            // The write issued this cycle always completes and is counted,
            // even when an abort arrives alongside it.
            words_d = words_q + CNT_W'(1);
            addr_d  = addr_q + 32'd4;
            lane_d  = 2'd0;
            if (load_abort) begin
               state_d = S_ERR;
            end else if (last_word) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RECV;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         words_q <= '0;
         lane_q  <= 2'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         state_q <= state_d;
         n_q     <= n_d;
         words_q <= words_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Outputs are decoded straight from registered state, so reset clears them at once.
   assign byte_ready    = (state_q == S_RECV);
   assign mem_we        = (state_q == S_WRITE);
   assign cpu_hold      = (state_q == S_RECV) || (state_q == S_WRITE);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERR);
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed byte streams, a table of
// load-size requests, abort/reset/restart corner sequences.
module tb_imem_loader;

   localparam int unsigned MEM_BYTES = 36;
   localparam int unsigned CNT_W     = 8;

   logic             clk;
   logic             reset;
   logic             load_start;
   logic [CNT_W-1:0] load_words;
   logic             load_abort;
   logic [7:0]       byte_data;
   logic             byte_valid;
   logic             byte_ready;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             cpu_hold;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] words_written;

   imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .load_start    (load_start),
      .load_words    (load_words),
      .load_abort    (load_abort),
      .byte_data     (byte_data),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Write monitor and protocol observers, sampled on the falling edge.
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          ready_viol = 0;  // cpu_hold without mem_we yet byte_ready low
   int          pulse_viol = 0;  // mem_we high two cycles in a row
   int          hold_viol  = 0;  // mem_we without cpu_hold
   logic        prev_we    = 1'b0;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
      if (cpu_hold && !mem_we && !byte_ready) ready_viol++;
      if (mem_we && prev_we) pulse_viol++;
      if (mem_we && !cpu_hold) hold_viol++;
      prev_we = mem_we;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int n);
      load_words = CNT_W'(n);
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int c;
      byte_valid = 1'b0;
      repeat (gap) step();
      byte_valid = 1'b1;
      byte_data  = b;
      c = 0;
      while (!byte_ready && c < 50) begin
         step();
         c++;
      end
      if (!byte_ready) begin
         check("send_byte_timeout", 32'(byte_ready), 32'd1);
         byte_valid = 1'b0;
         return;
      end
      step();
      byte_valid = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int c;
      c = 0;
      while (!done && !error && c < 50) begin
         step();
         c++;
      end
      check(name, 32'(done | error), 32'd1);
   endtask

   task automatic clear_writes();
      wr_addr.delete();
      wr_data.delete();
   endtask

   typedef struct {
      int   words;
      logic exp_err;
   } start_vec_t;

   start_vec_t  vecs[6];
   logic [7:0]  t1_bytes[8];
   logic [7:0]  big[36];
   logic [31:0] exp_word;
   int          snap;

   initial begin
      vecs[0] = '{words: 10,  exp_err: 1'b1};
      vecs[1] = '{words: 0,   exp_err: 1'b1};
      vecs[2] = '{words: 255, exp_err: 1'b1};
      vecs[3] = '{words: 1,   exp_err: 1'b0};
      vecs[4] = '{words: 9,   exp_err: 1'b0};
      vecs[5] = '{words: 4,   exp_err: 1'b0};

      t1_bytes = '{8'h33, 8'h01, 8'h10, 8'h00, 8'hb3, 8'h82, 8'h41, 8'h40};
      for (int i = 0; i < 36; i++) big[i] = 8'(i * 7 + 1);

      reset      = 1'b0;
      load_start = 1'b0;
      load_words = '0;
      load_abort = 1'b0;
      byte_data  = 8'h00;
      byte_valid = 1'b0;

      // Reset state.
      #2;
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      check("rst_done_error", 32'({done, error}), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_words_written", 32'(words_written), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();

      // 1: two words back-to-back.
      clear_writes();
      start_load(2);
      check("t1_ready_after_start", 32'(byte_ready), 32'd1);
      check("t1_hold_after_start", 32'(cpu_hold), 32'd1);
      for (int i = 0; i < 8; i++) send_byte(t1_bytes[i], 0);
      wait_end("t1_end_timeout");
      check("t1_nwrites", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check("t1_addr0", wr_addr[0], 32'd0);
         check("t1_data0", wr_data[0], 32'h00100133);
         check("t1_addr1", wr_addr[1], 32'd4);
         check("t1_data1", wr_data[1], 32'h404182b3);
      end
      check("t1_done", 32'(done), 32'd1);
      check("t1_error", 32'(error), 32'd0);
      check("t1_words", 32'(words_written), 32'd2);
      check("t1_hold", 32'(cpu_hold), 32'd0);

      // 2: same stream with 0..3 idle cycles between bytes.
      clear_writes();
      ready_viol = 0;
      pulse_viol = 0;
      hold_viol  = 0;
      start_load(2);
      for (int i = 0; i < 8; i++) send_byte(t1_bytes[i], (i * 3 + 1) % 4);
      wait_end("t2_end_timeout");
      check("t2_nwrites", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check("t2_data0", wr_data[0], 32'h00100133);
         check("t2_addr1", wr_addr[1], 32'd4);
         check("t2_data1", wr_data[1], 32'h404182b3);
      end
      check("t2_ready_low_only_in_write", 32'(ready_viol), 32'd0);
      check("t2_we_single_cycle", 32'(pulse_viol), 32'd0);
      check("t2_we_implies_hold", 32'(hold_viol), 32'd0);
      check("t2_done_words", 32'({done, words_written}), {23'd0, 1'b1, 8'd2});

      // 3: fill the whole 36-byte memory.
      clear_writes();
      start_load(9);
      for (int i = 0; i < 36; i++) send_byte(big[i], i % 2);
      wait_end("t3_end_timeout");
      check("t3_nwrites", 32'(wr_addr.size()), 32'd9);
      if (wr_addr.size() == 9) begin
         exp_word = {big[35], big[34], big[33], big[32]};
         check("t3_last_addr", wr_addr[8], 32'd32);
         check("t3_last_data", wr_data[8], exp_word);
         exp_word = {big[15], big[14], big[13], big[12]};
         check("t3_word3_data", wr_data[3], exp_word);
      end
      check("t3_done", 32'(done), 32'd1);
      check("t3_words", 32'(words_written), 32'd9);

      // Table of load sizes: accepted ones enter RECV, rejected ones go to ERR.
      for (int v = 0; v < 6; v++) begin
         snap = wr_addr.size();
         start_load(vecs[v].words);
         check($sformatf("vec%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
         check($sformatf("vec%0d_ready", v), 32'(byte_ready), 32'(!vecs[v].exp_err));
         check($sformatf("vec%0d_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_err));
         step();
         step();
         check($sformatf("vec%0d_ready_held", v), 32'(byte_ready), 32'(!vecs[v].exp_err));
         check($sformatf("vec%0d_done", v), 32'(done), 32'd0);
         if (!vecs[v].exp_err) begin
            load_abort = 1'b1;
            step();
            load_abort = 1'b0;
            check($sformatf("vec%0d_abort_err", v), 32'(error), 32'd1);
         end
         check($sformatf("vec%0d_no_write", v), 32'(wr_addr.size()), 32'(snap));
      end

      // 4: abort in RECV after six bytes of a three-word load.
      clear_writes();
      start_load(3);
      for (int i = 0; i < 6; i++) send_byte(big[i], 0);
      load_abort = 1'b1;
      step();
      load_abort = 1'b0;
      check("t4_error", 32'(error), 32'd1);
      check("t4_hold", 32'(cpu_hold), 32'd0);
      check("t4_ready", 32'(byte_ready), 32'd0);
      check("t4_words", 32'(words_written), 32'd1);
      check("t4_nwrites", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         check("t4_addr0", wr_addr[0], 32'd0);
         check("t4_data0", wr_data[0], {big[3], big[2], big[1], big[0]});
      end
      // Reload after the abort starts again at address 0.
      clear_writes();
      start_load(1);
      check("t4_restart_error_cleared", 32'(error), 32'd0);
      for (int i = 0; i < 4; i++) send_byte(t1_bytes[4 + i], 0);
      wait_end("t4_restart_timeout");
      check("t4_restart_nwrites", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         check("t4_restart_addr", wr_addr[0], 32'd0);
         check("t4_restart_data", wr_data[0], 32'h404182b3);
      end
      check("t4_restart_done_words", 32'({done, words_written}), {23'd0, 1'b1, 8'd1});

      // Abort during the WRITE cycle: that write still completes and counts.
      clear_writes();
      start_load(2);
      for (int i = 0; i < 4; i++) send_byte(t1_bytes[i], 0);
      check("tw_in_write", 32'(mem_we), 32'd1);
      load_abort = 1'b1;
      step();
      load_abort = 1'b0;
      check("tw_error", 32'(error), 32'd1);
      check("tw_words", 32'(words_written), 32'd1);
      check("tw_nwrites", 32'(wr_addr.size()), 32'd1);

      // Abort together with start from an idle-like state: start wins.
      load_abort = 1'b1;
      start_load(1);
      load_abort = 1'b0;
      check("tas_start_wins", 32'({byte_ready, error}), 32'b10);
      for (int i = 0; i < 4; i++) send_byte(t1_bytes[i], 0);
      wait_end("tas_timeout");
      check("tas_done", 32'(done), 32'd1);

      // 5: asynchronous reset between edges in the middle of a load.
      clear_writes();
      start_load(2);
      send_byte(8'haa, 0);
      send_byte(8'h55, 0);
      #3;
      reset = 1'b0;
      #1;
      check("t5_ready", 32'(byte_ready), 32'd0);
      check("t5_hold", 32'(cpu_hold), 32'd0);
      check("t5_we_done_err", 32'({mem_we, done, error}), 32'd0);
      check("t5_addr", mem_addr, 32'd0);
      check("t5_wdata", mem_wdata, 32'd0);
      check("t5_words", 32'(words_written), 32'd0);
      step();
      step();
      reset = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      repeat (10) step();
      byte_valid = 1'b0;
      check("t5_idle_no_write", 32'(wr_addr.size()), 32'd0);
      check("t5_idle_ready", 32'(byte_ready), 32'd0);
      check("t5_idle_flags", 32'({done, error, cpu_hold}), 32'd0);

      // 6: start pulses during RECV and WRITE are ignored.
      clear_writes();
      start_load(2);
      for (int i = 0; i < 3; i++) send_byte(t1_bytes[i], 0);
      start_load(1);
      send_byte(t1_bytes[3], 0);
      check("t6_in_write", 32'(mem_we), 32'd1);
      start_load(5);
      for (int i = 4; i < 8; i++) send_byte(t1_bytes[i], 0);
      wait_end("t6_end_timeout");
      check("t6_nwrites", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check("t6_data0", wr_data[0], 32'h00100133);
         check("t6_data1", wr_data[1], 32'h404182b3);
      end
      check("t6_done_words", 32'({done, words_written}), {23'd0, 1'b1, 8'd2});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
